// File: rtl/smi_frame_buffer.sv
// Flit FIFO for SMI request frames ahead of the AXI adaptor request port, with a registered output stage.
// Define SMI_FRAME_BUFFER_SAF_EN to hold each frame back until it is fully buffered (store-and-forward).
module smi_frame_buffer #(
  parameter int FlitWidth = 8,
  parameter int FifoDepth = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   smiInReady,
  input  logic [7:0]             smiInEofc,
  input  logic [FlitWidth*8-1:0] smiInData,
  output logic                   smiInStop,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop,
  output logic [7:0]             fillLevel,
  output logic [7:0]             frameCount
);

  localparam int DataW = FlitWidth * 8;
  localparam int PtrW  = $clog2(FifoDepth);
  localparam int CntW  = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);

  function automatic logic [7:0] stepCount(input logic [7:0] cnt, input logic inc, input logic dec);
    logic [7:0] res;
    res = cnt;
    if (inc && !dec)
      res = cnt + 8'd1;
    else if (dec && !inc)
      res = cnt - 8'd1;
    return res;
  endfunction

  logic [DataW+7:0] mem [FifoDepth];
  logic [PtrW-1:0]  wrPtr, rdPtr;
  logic [CntW-1:0]  entries;
  logic [7:0]       headEofc_p0;
  logic [DataW-1:0] headData_p0;
  logic             vld_p1;
  logic [7:0]       eofc_p1;
  logic [DataW-1:0] data_p1;
  logic             push, pop, outXfer, outFree, releaseEn;

  assign smiInStop = (entries == FullCnt);
  assign push      = smiInReady && !smiInStop;
  assign outXfer   = vld_p1 && !smiOutStop;
  assign outFree   = !vld_p1 || outXfer;
  assign pop       = releaseEn && outFree && (entries != '0);

  assign {headEofc_p0, headData_p0} = mem[rdPtr];

  // ---- p0: FIFO storage and pointers ----
  always_ff @(posedge clk) begin
    if (push)
      mem[wrPtr] <= {smiInEofc, smiInData};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      entries <= '0;
    end else begin
      if (push)
        wrPtr <= wrPtr + PtrW'(1);
      if (pop)
        rdPtr <= rdPtr + PtrW'(1);
      case ({push, pop})
        2'b10:   entries <= entries + CntW'(1);
        2'b01:   entries <= entries - CntW'(1);
        default: entries <= entries;
      endcase
    end
  end

`ifdef SMI_FRAME_BUFFER_SAF_EN
  typedef enum logic {Idle, Release} relState_e;
  relState_e       state, stateNext;
  logic [CntW-1:0] fifoFrames;

  // Final flits still inside the FIFO, excluding the output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifoFrames <= '0;
      state      <= Idle;
    end else begin
      state <= stateNext;
      case ({push && (smiInEofc != 8'd0), pop && (headEofc_p0 != 8'd0)})
        2'b10:   fifoFrames <= fifoFrames + CntW'(1);
        2'b01:   fifoFrames <= fifoFrames - CntW'(1);
        default: fifoFrames <= fifoFrames;
      endcase
    end
  end

  // A full FIFO also releases, so frames longer than the FIFO cut through instead of deadlocking.
  always_comb begin
    stateNext = state;
    releaseEn = 1'b0;
    case (state)
      Idle: begin
        if ((fifoFrames != '0) || (entries == FullCnt))
          stateNext = Release;
      end
      Release: begin
        releaseEn = 1'b1;
        if (pop && (headEofc_p0 != 8'd0))
          stateNext = Idle;
      end
    endcase
  end
`else
  assign releaseEn = 1'b1;
`endif

  // ---- p1: output register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1  <= 1'b0;
      eofc_p1 <= '0;
      data_p1 <= '0;
    end else if (pop) begin
      vld_p1  <= 1'b1;
      eofc_p1 <= headEofc_p0;
      data_p1 <= headData_p0;
    end else if (outXfer) begin
      vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fillLevel  <= '0;
      frameCount <= '0;
    end else begin
      fillLevel  <= stepCount(fillLevel, push, outXfer);
      frameCount <= stepCount(frameCount, push && (smiInEofc != 8'd0),
                              outXfer && (eofc_p1 != 8'd0));
    end
  end

  assign smiOutReady = vld_p1;
  assign smiOutEofc  = eofc_p1;
  assign smiOutData  = data_p1;

endmodule

// File: tb/tb_smi_frame_buffer.sv
// Randomised and directed bench for smi_frame_buffer against a queue-based reference model.
module tb_smi_frame_buffer;
  localparam int FlitWidth = 8;
  localparam int FifoDepth = 16;
`ifdef SMI_FRAME_BUFFER_SAF_EN
  localparam bit Saf = 1'b1;
`else
  localparam bit Saf = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        smiInReady = 1'b0;
  logic [7:0]  smiInEofc = '0;
  logic [63:0] smiInData = '0;
  logic        smiInStop;
  logic        smiOutReady;
  logic [7:0]  smiOutEofc;
  logic [63:0] smiOutData;
  logic        smiOutStop = 1'b0;
  logic [7:0]  fillLevel;
  logic [7:0]  frameCount;

  int checks = 0;
  int errors = 0;

  smi_frame_buffer #(.FlitWidth(FlitWidth), .FifoDepth(FifoDepth)) dut (
    .clk(clk), .rstn(rstn),
    .smiInReady(smiInReady), .smiInEofc(smiInEofc), .smiInData(smiInData), .smiInStop(smiInStop),
    .smiOutReady(smiOutReady), .smiOutEofc(smiOutEofc), .smiOutData(smiOutData), .smiOutStop(smiOutStop),
    .fillLevel(fillLevel), .frameCount(frameCount)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue, output stage as one slot, release as a flag.
  logic [71:0] q[$];
  bit          mVld = 1'b0;
  logic [71:0] mOut = '0;
  bit          mRel = 1'b0;
  bit          mAcc = 1'b0;

  always @(posedge clk or negedge rstn) begin
    bit full, anyFinal, xfer, load;
    logic [71:0] head;
    if (!rstn) begin
      q.delete();
      mVld = 1'b0;
      mOut = '0;
      mRel = 1'b0;
      mAcc = 1'b0;
    end else begin
      head = '0;
      full = (q.size() == FifoDepth);
      anyFinal = 1'b0;
      foreach (q[i]) if (q[i][71:64] != 8'd0) anyFinal = 1'b1;
      mAcc = smiInReady && !full;
      xfer = mVld && !smiOutStop;
      load = (!Saf || mRel) && (!mVld || xfer) && (q.size() != 0);
      if (load) begin
        head = q.pop_front();
        mOut = head;
        mVld = 1'b1;
      end else if (xfer) begin
        mVld = 1'b0;
      end
      if (mAcc) q.push_back({smiInEofc, smiInData});
      if (!mRel) mRel = anyFinal || full;
      else if (load && head[71:64] != 8'd0) mRel = 1'b0;
    end
  end

  function automatic int expFill();
    return q.size() + int'(mVld);
  endfunction

  function automatic int expFrames();
    int n = 0;
    foreach (q[i]) if (q[i][71:64] != 8'd0) n++;
    if (mVld && mOut[71:64] != 8'd0) n++;
    return n;
  endfunction

  function automatic logic [89:0] expVec();
    return {q.size() == FifoDepth, mVld, mVld ? mOut : 72'h0, 8'(expFill()), 8'(expFrames())};
  endfunction

  function automatic logic [89:0] dutVec();
    return {smiInStop, smiOutReady, smiOutReady ? {smiOutEofc, smiOutData} : 72'h0, fillLevel, frameCount};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    smiInReady = 1'b0;
    smiOutStop = 1'b0;
    repeat (2) tick();
    checks++;
    if ({smiOutReady, smiOutEofc, smiOutData, smiInStop, fillLevel, frameCount} !== 91'h0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b eofc=%h data=%h stop=%b fill=%0d frames=%0d want all zero",
               smiOutReady, smiOutEofc, smiOutData, smiInStop, fillLevel, frameCount);
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checks++;
    if (dutVec() !== expVec()) begin
      errors++;
      $display("FAIL reset_release got %h want %h", dutVec(), expVec());
    end
  endtask

  task automatic test_single();
    int lat;
    smiOutStop = 1'b0;
    smiInReady = 1'b1;
    smiInEofc = 8'd8;
    smiInData = 64'h1122334455667788;
    tick();
    smiInReady = 1'b0;
    lat = 1;
    checks++;
    if (frameCount !== 8'd1) begin
      errors++;
      $display("FAIL single_frames_in got %0d want 1", frameCount);
    end
    while (!smiOutReady && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != (Saf ? 3 : 2)) begin
      errors++;
      $display("FAIL single_latency got %0d edges want %0d", lat, Saf ? 3 : 2);
    end
    checks++;
    if ({smiOutEofc, smiOutData, frameCount} !== {8'd8, 64'h1122334455667788, 8'd1}) begin
      errors++;
      $display("FAIL single_flit got eofc=%h data=%h frames=%0d want 08 1122334455667788 1",
               smiOutEofc, smiOutData, frameCount);
    end
    tick();
    checks++;
    if ({smiOutReady, frameCount, fillLevel} !== 17'h0) begin
      errors++;
      $display("FAIL single_after_xfer got rdy=%b frames=%0d fill=%0d want 0 0 0",
               smiOutReady, frameCount, fillLevel);
    end
  endtask

  task automatic test_fill();
    smiOutStop = 1'b1;
    for (int i = 0; i < 18; i++) begin
      smiInReady = 1'b1;
      smiInEofc = 8'($urandom_range(1, 8));
      smiInData = {$urandom, $urandom};
      tick();
      checks++;
      if (dutVec() !== expVec()) begin
        errors++;
        $display("FAIL fill_model i=%0d got %h want %h", i, dutVec(), expVec());
      end
      if (i >= 16) begin
        checks++;
        if ({smiInStop, fillLevel, frameCount} !== {1'b1, 8'd17, 8'd17}) begin
          errors++;
          $display("FAIL fill_full i=%0d got stop=%b fill=%0d frames=%0d want 1 17 17",
                   i, smiInStop, fillLevel, frameCount);
        end
      end
    end
    smiInReady = 1'b0;
    smiOutStop = 1'b0;
    for (int c = 0; c < 100 && expFill() != 0; c++) begin
      tick();
      checks++;
      if (dutVec() !== expVec()) begin
        errors++;
        $display("FAIL fill_drain c=%0d got %h want %h", c, dutVec(), expVec());
      end
    end
    checks++;
    if (fillLevel !== 8'd0) begin
      errors++;
      $display("FAIL fill_drained got %0d want 0", fillLevel);
    end
  endtask

  task automatic test_stream();
    int inIdx = 0, outIdx = 0, cyc = 0;
    bit sawOut;
    logic [7:0] obsEofc;
    logic [63:0] obsData;
    smiOutStop = 1'b0;
    while (outIdx < 100 && cyc < 500) begin
      smiInReady = (inIdx < 100);
      smiInEofc = (inIdx % 4 == 3) ? 8'd8 : 8'd0;
      smiInData = 64'(inIdx);
      sawOut = smiOutReady;
      obsEofc = smiOutEofc;
      obsData = smiOutData;
      tick();
      cyc++;
      if (mAcc) inIdx++;
      if (sawOut) begin
        checks++;
        if ({obsEofc, obsData} !== {((outIdx % 4 == 3) ? 8'd8 : 8'd0), 64'(outIdx)}) begin
          errors++;
          $display("FAIL stream_order n=%0d got eofc=%h data=%0d want data=%0d", outIdx, obsEofc, obsData, outIdx);
        end
        outIdx++;
      end
      checks++;
      if (dutVec() !== expVec()) begin
        errors++;
        $display("FAIL stream_model cyc=%0d got %h want %h", cyc, dutVec(), expVec());
      end
    end
    smiInReady = 1'b0;
    checks++;
    if (outIdx != 100) begin
      errors++;
      $display("FAIL stream_count got %0d want 100", outIdx);
    end
  endtask

  task automatic test_saf_frame();
    int outCycles = 0;
    smiOutStop = 1'b0;
    for (int f = 0; f < 4; f++) begin
      smiInReady = 1'b1;
      smiInEofc = (f == 3) ? 8'd5 : 8'd0;
      smiInData = {$urandom, $urandom};
      tick();
      smiInReady = 1'b0;
      if (smiOutReady) outCycles++;
      checks++;
      if (dutVec() !== expVec()) begin
        errors++;
        $display("FAIL gapframe_model f=%0d got %h want %h", f, dutVec(), expVec());
      end
      for (int g = 0; g < ((f < 3) ? 3 : 8); g++) begin
        tick();
        if (smiOutReady) outCycles++;
        checks++;
        if (dutVec() !== expVec()) begin
          errors++;
          $display("FAIL gapframe_model f=%0d g=%0d got %h want %h", f, g, dutVec(), expVec());
        end
      end
    end
    checks++;
    if (outCycles != 4) begin
      errors++;
      $display("FAIL gapframe_count got %0d want 4", outCycles);
    end
  endtask

  task automatic test_reset_mid();
    smiOutStop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smiInReady = 1'b1;
      smiInEofc = 8'd0;
      smiInData = {$urandom, $urandom};
      tick();
    end
    smiInReady = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({smiOutReady, smiInStop, fillLevel, frameCount} !== 18'h0) begin
      errors++;
      $display("FAIL midreset got rdy=%b stop=%b fill=%0d frames=%0d want 0 0 0 0",
               smiOutReady, smiInStop, fillLevel, frameCount);
    end
    @(negedge clk);
    rstn = 1'b1;
    smiOutStop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      smiInReady = (i < 2);
      smiInEofc = (i == 1) ? 8'd3 : 8'd0;
      smiInData = {$urandom, $urandom};
      tick();
      checks++;
      if (dutVec() !== expVec()) begin
        errors++;
        $display("FAIL midreset_after i=%0d got %h want %h", i, dutVec(), expVec());
      end
    end
    checks++;
    if ({fillLevel, frameCount} !== 16'h0) begin
      errors++;
      $display("FAIL midreset_clean got fill=%0d frames=%0d want 0 0", fillLevel, frameCount);
    end
  endtask

  task automatic test_oversize();
    int inIdx = 0, outIdx = 0, cyc = 0;
    bit sawOut;
    logic [63:0] obsData;
    smiOutStop = 1'b0;
    while (outIdx < 20 && cyc < 200) begin
      smiInReady = (inIdx < 20);
      smiInEofc = (inIdx == 19) ? 8'd8 : 8'd0;
      smiInData = 64'(inIdx + 1000);
      sawOut = smiOutReady;
      obsData = smiOutData;
      tick();
      cyc++;
      if (mAcc) inIdx++;
      if (sawOut) begin
        checks++;
        if (obsData !== 64'(outIdx + 1000)) begin
          errors++;
          $display("FAIL oversize_order n=%0d got %0d want %0d", outIdx, obsData, outIdx + 1000);
        end
        outIdx++;
      end
      checks++;
      if (dutVec() !== expVec()) begin
        errors++;
        $display("FAIL oversize_model cyc=%0d got %h want %h", cyc, dutVec(), expVec());
      end
    end
    smiInReady = 1'b0;
    checks++;
    if (outIdx != 20) begin
      errors++;
      $display("FAIL oversize_count got %0d want 20", outIdx);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      smiInReady = ($urandom_range(0, 3) != 0);
      smiInEofc = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 8)) : 8'd0;
      smiInData = {$urandom, $urandom};
      smiOutStop = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (dutVec() !== expVec()) begin
        errors++;
        $display("FAIL random c=%0d got %h want %h", c, dutVec(), expVec());
      end
    end
    smiOutStop = 1'b0;
    smiInReady = 1'b1;
    smiInEofc = 8'd1;
    for (int c = 0; c < 200 && (expFill() != 0 || smiInReady); c++) begin
      tick();
      if (mAcc) smiInReady = 1'b0;
      checks++;
      if (dutVec() !== expVec()) begin
        errors++;
        $display("FAIL random_drain c=%0d got %h want %h", c, dutVec(), expVec());
      end
    end
    smiInReady = 1'b0;
    checks++;
    if (fillLevel !== 8'd0) begin
      errors++;
      $display("FAIL random_drained got %0d want 0", fillLevel);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_saf_frame();
    test_reset_mid();
    test_oversize();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
